// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM encoding,
// mode constants and the digit-count helper.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/addsub_serial_if.sv
// Start/done handshake plus operand and result bus of the serial adder/subtractor.
interface addsub_serial_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             V;
  logic             Z;
  logic             done;

  modport master (output start, A, B, Cin, input ready, S, Cout, V, Z, done);
  modport slave  (input start, A, B, Cin, output ready, S, Cout, V, Z, done);
endinterface

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple adder; c_msb is the carry into the top bit
// so the caller can form signed overflow on the last digit.
module addsub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial A+B / A-B: one DIGIT slice per clock, LSB first, with the
// result and flags published only at the final step.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  addsub_serial_if.slave bus
);

  localparam int N     = num_digits(WIDTH, DIGIT);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $fatal(1, "addsub_serial: WIDTH must be a multiple of DIGIT with 1 <= DIGIT <= WIDTH");
  end

  state_t           st;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             v_q;
  logic             z_q;
  logic             ready_q;
  logic             done_q;

  logic [DIGIT-1:0] d_sum;
  logic             d_cout;
  logic             d_cmsb;
  logic [WIDTH-1:0] full;

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a     (a_sh[DIGIT-1:0]),
    .b     (b_sh[DIGIT-1:0]),
    .cin   (carry),
    .sum   (d_sum),
    .cout  (d_cout),
    .c_msb (d_cmsb)
  );

  // Completed upper slices accumulate right-to-left; the new slice enters at the top.
  if (N == 1) begin : g_single
    assign full = d_sum;
  end else begin : g_multi
    logic [WIDTH-DIGIT-1:0] acc;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc <= '0;
      end else if (st == RUN) begin
        acc <= full[WIDTH-1:DIGIT];
      end
    end

    assign full = {d_sum, acc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh    <= bus.A;
            // Subtraction is A + ~B + 1: invert B and seed the carry with the mode bit.
            b_sh    <= bus.B ^ {WIDTH{bus.Cin == MODE_SUB}};
            carry   <= bus.Cin;
            cnt     <= '0;
            ready_q <= 1'b0;
            st      <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          carry <= d_cout;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(N - 1)) begin
            s_q    <= full;
            cout_q <= d_cout;
            v_q    <= d_cmsb ^ d_cout;
            z_q    <= (full == '0);
            done_q <= 1'b1;
            st     <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          st      <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          st      <= IDLE;
        end
      endcase
    end
  end

  assign bus.S     = s_q;
  assign bus.Cout  = cout_q;
  assign bus.V     = v_q;
  assign bus.Z     = z_q;
  assign bus.ready = ready_q;
  assign bus.done  = done_q;

endmodule
